mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Memory-access (MEM) stage; sits directly downstream of the EX/MEM pipeline register and feeds the MEM/WB register.
- Turns MemRead/MemWrite into a valid/ready data-memory transaction with byte-lane steering, load sign/zero extension and a response timeout.
- Holds the pipeline via stall_out until the access completes.
- Resolves the branch decision (Branch & zero).

Parameters:
- XLEN, 64, datapath and address width.
- TIMEOUT_CYCLES, 255, max cycles in REQ+RESP before bus error; 8-bit counter, legal 1..255.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted at 0)
- pc_in  input  XLEN  PC from EX/MEM
- alu_result_in  input  XLEN  effective address / ALU result
- data2_in  input  XLEN  store data
- rd_in  input  5  destination register
- branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, zero_in  input  1 each  control from EX/MEM
- mem_size_in  input  2  0=byte 1=half 2=word 3=dword
- mem_unsigned_in  input  1  zero-extend loads when 1
- dmem_req_valid  output  1  request valid
- dmem_req_ready  input  1  memory accepts request
- dmem_addr  output  XLEN  address, aligned to 8 (low 3 bits zero)
- dmem_we  output  1  1=store
- dmem_wdata  output  XLEN  store data shifted to lane
- dmem_wstrb  output  8  byte strobes
- dmem_rsp_valid  input  1  response/ack (loads and stores)
- dmem_rdata  input  XLEN  load data, full doubleword
- stall_out  output  1  freeze EX/MEM and earlier stages
- pcsrc_out  output  1  branch_in & zero_in (combinational)
- load_data_out  output  XLEN  extended load result to MEM/WB
- alu_result_out, rd_out, mem_to_reg_out, reg_write_out  output  XLEN/5/1/1  pass-through to MEM/WB
- bus_err_out  output  1  one-cycle pulse on timeout

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, captured address/data/size/unsigned cleared, dmem_req_valid=0, bus_err_out=0. load_data_out=0 whenever no completion is occurring.
- mem_op = mem_read_in | mem_write_in; both set treated as a store.
- Non-memory op: zero latency, stall_out=0, pass-throughs combinational.
- FSM:
  - IDLE: on mem_op, capture address/data/size/unsigned and go to REQ.
  - REQ: dmem_req_valid=1; signals held stable until dmem_req_ready; handshake cycle → RESP.
  - RESP: wait for dmem_rsp_valid. Completion cycle → IDLE.
- stall_out = mem_op & ~complete, where complete = (RESP & dmem_rsp_valid) | timeout. Minimum memory-op latency: 3 cycles (IDLE, REQ with ready, RESP with rsp).
- Lane steering, lane = addr[2:0]:
  - wstrb: byte=1<<lane, half=3<<lane, word=0xF<<lane, dword=0xFF.
  - wdata = data2_in << (8*lane).
  - Loads: (rdata >> 8*lane), truncated to size, then sign- or zero-extended.
- load_data_out valid only in the completion cycle; combinational from dmem_rdata. Otherwise 0.
- Timeout:
  - Counter increments each cycle in REQ/RESP and clears on IDLE entry.
  - When it reaches TIMEOUT_CYCLES: bus_err_out=1 for one cycle, complete=1, load_data_out=0, → IDLE.
- dmem_rsp_valid in IDLE or REQ is ignored.
- reg_write_out is forced 0 in a bus-error cycle.
- Reset mid-transaction: request dropped immediately; any late response is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: an access not naturally aligned (half addr[0]≠0, word addr[1:0]≠0, dword addr[2:0]≠0) issues no request. In that case:
  - misalign_fault_out (extra 1-bit output) pulses for one cycle;
  - the stage completes in the IDLE cycle;
  - reg_write_out=0, load_data_out=0.
- Undefined: no fault port; misaligned lanes are truncated by the shift/strobe rules (bytes beyond lane 7 dropped).

Decomposition:
- Shared package mem_pkg: mem_size_t enum (MEM_B, MEM_H, MEM_W, MEM_D), state enum (ST_IDLE, ST_REQ, ST_RESP), XLEN default.
- One sub-module: mem_lane_align (combinational store strobe/shift and load extract/extend). Reused by a future cache.

Test Plan:
- Load dword, addr 0x1000, ready=1 first REQ cycle, rsp next cycle with rdata 0x1122334455667788 → load_data_out 0x1122334455667788; stall high 2 cycles.
- Load byte signed, addr 0x1003, rdata 0x00000000_80000000 → lane 3 byte 0x80 → load_data_out 0xFFFFFFFFFFFFFF80. Same with unsigned → 0x80.
- Store half, addr 0x2006, data2 0xBEEF → dmem_addr 0x2000, wstrb 0xC0, wdata 0xBEEF000000000000, dmem_we=1.
- ready held 0 for 4 cycles → dmem_req_valid and dmem_addr stable throughout; handshake on cycle 5.
- No rsp with TIMEOUT_CYCLES=8 → bus_err_out pulse on 8th cycle after IDLE exit; stall drops; reg_write_out=0.
- reset driven low while in RESP → dmem_req_valid=0 and state IDLE immediately; rsp arriving after release is ignored. With MEM_MISALIGN_TRAP_EN, word load at 0x1002 → no request, misalign_fault_out pulse.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage and its lane-alignment helper.
// Also provides the natural-alignment test used when MEM_MISALIGN_TRAP_EN is defined.
package mem_pkg;

  localparam int XLEN_DEFAULT = 64;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [2:0] lane);
    case (size)
      MEM_H:   return lane[0];
      MEM_W:   return |lane[1:0];
      MEM_D:   return |lane;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store strobes/shift and load extract/extend.
// Lanes shifted past byte 7 are dropped; doublewords always strobe every lane.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      lane,
  input  mem_size_t       size,
  input  logic            is_unsigned,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] load_rdata,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data
);

  logic [5:0]      shamt;
  logic [XLEN-1:0] rdata_sh;

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v, input mem_size_t s,
                                             input logic u);
    case (s)
      MEM_B:   return {{(XLEN-8){v[7] & ~u}}, v[7:0]};
      MEM_H:   return {{(XLEN-16){v[15] & ~u}}, v[15:0]};
      MEM_W:   return {{(XLEN-32){v[31] & ~u}}, v[31:0]};
      default: return v;
    endcase
  endfunction

  assign shamt    = {lane, 3'b000};
  assign wdata    = store_data << shamt;
  assign rdata_sh = load_rdata >> shamt;

  always_comb begin
    wstrb = 8'h00;
    case (size)
      MEM_B:   wstrb = 8'h01 << lane;
      MEM_H:   wstrb = 8'h03 << lane;
      MEM_W:   wstrb = 8'h0F << lane;
      default: wstrb = 8'hFF;
    endcase
  end

  assign load_data = extend(rdata_sh, size, is_unsigned);

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: valid/ready data-memory access with lane steering, response timeout and stall.
// Define MEM_MISALIGN_TRAP_EN to fault misaligned accesses instead of issuing them.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int XLEN           = XLEN_DEFAULT,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] alu_result_in,
  input  logic [XLEN-1:0] data2_in,
  input  logic [4:0]      rd_in,
  input  logic            branch_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic            mem_to_reg_in,
  input  logic            reg_write_in,
  input  logic            zero_in,
  input  logic [1:0]      mem_size_in,
  input  logic            mem_unsigned_in,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [7:0]      dmem_wstrb,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            stall_out,
  output logic            pcsrc_out,
  output logic [XLEN-1:0] load_data_out,
  output logic [XLEN-1:0] alu_result_out,
  output logic [4:0]      rd_out,
  output logic            mem_to_reg_out,
  output logic            reg_write_out,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            misalign_fault_out,
`endif
  output logic            bus_err_out
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t          state;
  logic [7:0]      cnt;
  logic [XLEN-1:0] cap_addr;
  logic [XLEN-1:0] cap_data;
  mem_size_t       cap_size;
  logic            cap_unsigned;
  logic            cap_we;

  logic            mem_op;
  logic            rsp_done;
  logic            timeout;
  logic            misalign;
  logic            complete;
  logic [XLEN-1:0] lane_load;
  logic            unused_pc;

  assign mem_op   = mem_read_in | mem_write_in;
  assign rsp_done = (state == ST_RESP) & dmem_rsp_valid;
  // A response landing on the last allowed cycle still counts as success.
  assign timeout  = (state != ST_IDLE) & (cnt == TMO_LAST) & ~rsp_done;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign = (state == ST_IDLE) & mem_op
                  & is_misaligned(mem_size_t'(mem_size_in), alu_result_in[2:0]);
  assign misalign_fault_out = misalign;
`else
  assign misalign = 1'b0;
`endif

  assign complete  = rsp_done | timeout | misalign;
  assign stall_out = mem_op & ~complete;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      cnt            <= 8'd0;
      cap_addr       <= '0;
      cap_data       <= '0;
      cap_size       <= MEM_B;
      cap_unsigned   <= 1'b0;
      cap_we         <= 1'b0;
      dmem_req_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= 8'd0;
          if (mem_op && !misalign) begin
            cap_addr       <= alu_result_in;
            cap_data       <= data2_in;
            cap_size       <= mem_size_t'(mem_size_in);
            cap_unsigned   <= mem_unsigned_in;
            cap_we         <= mem_write_in;
            dmem_req_valid <= 1'b1;
            state          <= ST_REQ;
          end
        end
        ST_REQ: begin
          cnt <= cnt + 8'd1;
          if (timeout) begin
            dmem_req_valid <= 1'b0;
            state          <= ST_IDLE;
          end else if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            state          <= ST_RESP;
          end
        end
        ST_RESP: begin
          cnt <= cnt + 8'd1;
          if (complete) state <= ST_IDLE;
        end
        default: begin
          dmem_req_valid <= 1'b0;
          state          <= ST_IDLE;
        end
      endcase
    end
  end

  assign dmem_addr = {cap_addr[XLEN-1:3], 3'b000};
  assign dmem_we   = cap_we;

  mem_lane_align #(.XLEN(XLEN)) u_lane_align (
    .lane        (cap_addr[2:0]),
    .size        (cap_size),
    .is_unsigned (cap_unsigned),
    .store_data  (cap_data),
    .load_rdata  (dmem_rdata),
    .wstrb       (dmem_wstrb),
    .wdata       (dmem_wdata),
    .load_data   (lane_load)
  );

  assign load_data_out  = (rsp_done & ~cap_we) ? lane_load : '0;
  assign bus_err_out    = timeout;
  assign pcsrc_out      = branch_in & zero_in;
  assign alu_result_out = alu_result_in;
  assign rd_out         = rd_in;
  assign mem_to_reg_out = mem_to_reg_in;
  assign reg_write_out  = reg_write_in & ~timeout & ~misalign;
  assign unused_pc      = ^pc_in;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: driver pushes modelled results, monitor pops on retire.
// Honours MEM_MISALIGN_TRAP_EN when the design is built with it.
module tb_mem_access_stage;

  localparam int T = 8;
`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, reset;
  logic [63:0] pc_in, alu_result_in, data2_in;
  logic [4:0]  rd_in;
  logic        branch_in, mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in, zero_in;
  logic [1:0]  mem_size_in;
  logic        mem_unsigned_in;
  logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic        stall_out, pcsrc_out, mem_to_reg_out, reg_write_out, bus_err_out;
  logic [63:0] load_data_out, alu_result_out;
  logic [4:0]  rd_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_fault_out;
`endif

  mem_access_stage #(.XLEN(64), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .alu_result_in(alu_result_in),
    .data2_in(data2_in), .rd_in(rd_in), .branch_in(branch_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .zero_in(zero_in), .mem_size_in(mem_size_in), .mem_unsigned_in(mem_unsigned_in),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
    .dmem_we(dmem_we), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata), .stall_out(stall_out),
    .pcsrc_out(pcsrc_out), .load_data_out(load_data_out), .alu_result_out(alu_result_out),
    .rd_out(rd_out), .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_fault_out(misalign_fault_out),
`endif
    .bus_err_out(bus_err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, br, zr, rw, m2r, uns;
    logic [1:0]  size;
    logic [4:0]  rd_idx;
    logic [63:0] pc, addr, data, rdata;
    int          r, d;
    bit          noise;
  } op_t;

  typedef struct {
    int          lat, req_cyc, hs;
    logic [63:0] alu, addr, wdata, load;
    logic [7:0]  wstrb;
    logic [4:0]  rd_idx;
    logic        we, pcsrc, m2r, rw, bus, fault, chk_load, is_store;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0, n_pass = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  // Reference: what the stage must produce for one EX/MEM instruction.
  function automatic exp_t model(input op_t o);
    exp_t e;
    int n, lane, total;
    bit mem, mis, ok;
    logic [63:0] val, mask;
    e = '{default: 0};
    n = 1 << o.size;
    lane = int'(o.addr[2:0]);
    mem = o.rd | o.wr;
    mis = (lane % n) != 0;
    e.alu = o.addr; e.rd_idx = o.rd_idx; e.pcsrc = o.br & o.zr; e.m2r = o.m2r;
    e.rw = o.rw; e.chk_load = 1'b1; e.lat = 1; e.load = 64'd0;
    e.is_store = o.wr; e.we = o.wr; e.addr = {o.addr[63:3], 3'b000};
    e.wdata = o.data << (8 * lane);
    e.wstrb = 8'h00;
    if (o.size == 2'd3) e.wstrb = 8'hFF;
    else for (int i = 0; i < n; i++) if (lane + i < 8) e.wstrb[lane+i] = 1'b1;
    if (mem && mis && TRAP) begin
      e.fault = 1'b1;
      e.rw = 1'b0;
    end else if (mem) begin
      total = o.r + o.d + 2;
      ok = total <= T;
      e.lat = (ok ? total : T) + 1;
      e.req_cyc = (o.r + 1 < T) ? o.r + 1 : T;
      e.hs = (o.r + 1 <= T) ? 1 : 0;
      e.bus = !ok;
      e.rw = o.rw & ok;
      e.chk_load = !o.wr;
      if (ok && !o.wr) begin
        val = 64'd0;
        for (int i = 0; i < n; i++)
          if (lane + i < 8) val[8*i +: 8] = o.rdata[8*(lane+i) +: 8];
        mask = (n == 8) ? {64{1'b1}} : (64'd1 << (8 * n)) - 64'd1;
        if (!o.uns && n < 8 && val[8*n-1]) val = val | ~mask;
        e.load = val;
      end
    end
    return e;
  endfunction

  function automatic op_t mk(input logic rd, input logic wr, input logic [1:0] size,
                             input logic uns, input logic [63:0] addr, input logic [63:0] data,
                             input logic [63:0] rdata, input int r, input int d);
    op_t o;
    o.rd = rd; o.wr = wr; o.size = size; o.uns = uns; o.addr = addr; o.data = data;
    o.rdata = rdata; o.r = r; o.d = d; o.noise = 1'b0;
    o.br = 1'b0; o.zr = 1'b0; o.rw = 1'b1; o.m2r = rd; o.rd_idx = 5'd5; o.pc = 64'h400;
    return o;
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int k;
    k = $urandom_range(0, 3);
    o.rd = (k == 1) || (k == 3);
    o.wr = (k == 2) || (k == 3);
    o.size = 2'($urandom_range(0, 3));
    o.uns = 1'($urandom_range(0, 1));
    o.addr = {$urandom, $urandom};
    o.data = {$urandom, $urandom};
    o.rdata = {$urandom, $urandom};
    o.r = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 10) : $urandom_range(0, 3);
    o.d = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 12) : $urandom_range(0, 3);
    o.noise = 1'b1;
    o.br = 1'($urandom_range(0, 1)); o.zr = 1'($urandom_range(0, 1));
    o.rw = 1'($urandom_range(0, 1)); o.m2r = 1'($urandom_range(0, 1));
    o.rd_idx = 5'($urandom_range(0, 31)); o.pc = {$urandom, $urandom};
    return o;
  endfunction

  // Memory side for cycle c of an instruction (c=0 is the cycle it is presented).
  task automatic drive_mem(input op_t o, input int c);
    int hs_c, rs_c;
    hs_c = o.r + 1;
    rs_c = o.r + o.d + 2;
    dmem_rdata = {$urandom, $urandom};
    if (c == 0) dmem_req_ready = o.noise ? 1'($urandom_range(0, 1)) : 1'b0;
    else if (c < hs_c) dmem_req_ready = 1'b0;
    else if (c == hs_c) dmem_req_ready = 1'b1;
    else dmem_req_ready = o.noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (c == rs_c) begin
      dmem_rsp_valid = 1'b1;
      dmem_rdata = o.rdata;
    end else if (c <= hs_c && o.noise) dmem_rsp_valid = 1'($urandom_range(0, 1));
    else dmem_rsp_valid = 1'b0;
  endtask

  task automatic run_op(input op_t o);
    bit done;
    exp_q.push_back(model(o));
    pc_in = o.pc; alu_result_in = o.addr; data2_in = o.data; rd_in = o.rd_idx;
    branch_in = o.br; zero_in = o.zr; mem_read_in = o.rd; mem_write_in = o.wr;
    mem_to_reg_in = o.m2r; reg_write_in = o.rw; mem_size_in = o.size; mem_unsigned_in = o.uns;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
      end
      drive_mem(o, c);
      @(negedge clk);
      done = !stall_out;
    end
    if (!done) begin
      $display("FAIL retire_timeout: stall_out still 1 after 40 cycles, required 0");
      $fatal(1, "stage never released the pipeline");
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    int   cyc, req_seen, hs_seen;
    exp_t e;
    cyc = 0; req_seen = 0; hs_seen = 0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_empty", 64'd1, 64'd0);
        end else begin
          e = exp_q[0];
          cyc++;
          if (dmem_req_valid) begin
            req_seen++;
            chk("req_addr", dmem_addr, e.addr);
            chk("req_we", 64'(dmem_we), 64'(e.we));
            if (e.is_store) begin
              chk("req_wstrb", 64'(dmem_wstrb), 64'(e.wstrb));
              chk("req_wdata", dmem_wdata, e.wdata);
            end
            if (dmem_req_ready) hs_seen++;
          end
          if (stall_out) begin
            chk("stall_load_data", load_data_out, 64'd0);
            chk("stall_bus_err", 64'(bus_err_out), 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
            chk("stall_fault", 64'(misalign_fault_out), 64'd0);
`endif
          end else begin
            chk("latency", 64'(cyc), 64'(e.lat));
            chk("req_cycles", 64'(req_seen), 64'(e.req_cyc));
            chk("handshakes", 64'(hs_seen), 64'(e.hs));
            chk("alu_result", alu_result_out, e.alu);
            chk("rd", 64'(rd_out), 64'(e.rd_idx));
            chk("pcsrc", 64'(pcsrc_out), 64'(e.pcsrc));
            chk("mem_to_reg", 64'(mem_to_reg_out), 64'(e.m2r));
            chk("reg_write", 64'(reg_write_out), 64'(e.rw));
            chk("bus_err", 64'(bus_err_out), 64'(e.bus));
            if (e.chk_load) chk("load_data", load_data_out, e.load);
`ifdef MEM_MISALIGN_TRAP_EN
            chk("misalign_fault", 64'(misalign_fault_out), 64'(e.fault));
`endif
            void'(exp_q.pop_front());
            cyc = 0; req_seen = 0; hs_seen = 0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0;
    pc_in = '0; alu_result_in = '0; data2_in = '0; rd_in = '0;
    branch_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 0; reg_write_in = 0;
    zero_in = 0; mem_size_in = 0; mem_unsigned_in = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_valid", 64'(dmem_req_valid), 64'd0);
    chk("reset_bus_err", 64'(bus_err_out), 64'd0);
    chk("reset_load_data", load_data_out, 64'd0);
    chk("reset_stall", 64'(stall_out), 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 mon_en = 1'b1;

    run_op(mk(1, 0, 2'd3, 0, 64'h1000, 64'h0, 64'h1122334455667788, 0, 0));
    run_op(mk(1, 0, 2'd0, 0, 64'h1003, 64'h0, 64'h0000000080000000, 0, 0));
    run_op(mk(1, 0, 2'd0, 1, 64'h1003, 64'h0, 64'h0000000080000000, 0, 0));
    run_op(mk(0, 1, 2'd1, 0, 64'h2006, 64'hBEEF, 64'h0, 0, 0));
    run_op(mk(1, 0, 2'd2, 0, 64'h1014, 64'h0, 64'h8765432100000000, 4, 1));
    run_op(mk(1, 0, 2'd3, 0, 64'h1018, 64'h0, 64'hDEADBEEFCAFEF00D, 0, 20));
    run_op(mk(0, 1, 2'd2, 0, 64'h1020, 64'h12345678, 64'h0, 10, 0));
    run_op(mk(1, 0, 2'd1, 0, 64'h1028, 64'h0, 64'h000000000000F00F, 2, 4));
    run_op(mk(1, 0, 2'd2, 0, 64'h1002, 64'h0, 64'hFFFFFFFF11223344, 0, 0));
    run_op(mk(1, 1, 2'd1, 1, 64'h1037, 64'hA1B2, 64'h0, 1, 0));
    for (int i = 0; i < 150; i++) run_op(rand_op());

    mon_en = 1'b0;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    for (int v = 0; v < 2; v++) begin
      mem_read_in = 1; mem_write_in = 0; mem_size_in = 2'd3; reg_write_in = 1;
      alu_result_in = 64'h3000 + 64'(v * 8);
      dmem_req_ready = 0; dmem_rsp_valid = 0;
      @(posedge clk);
      #1 dmem_req_ready = (v == 1);
      if (v == 1) begin
        @(posedge clk);
        #1 dmem_req_ready = 0;
      end
      @(negedge clk);
      chk("pre_reset_req_valid", 64'(dmem_req_valid), (v == 0) ? 64'd1 : 64'd0);
      reset = 1'b0;
      #1;
      chk("mid_reset_req_valid", 64'(dmem_req_valid), 64'd0);
      chk("mid_reset_bus_err", 64'(bus_err_out), 64'd0);
      mem_read_in = 0; reg_write_in = 0;
      @(posedge clk);
      #1 reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
        dmem_rsp_valid = 1; dmem_rdata = {$urandom | 32'h1, $urandom};
        @(negedge clk);
        chk("late_rsp_load_data", load_data_out, 64'd0);
        chk("late_rsp_req_valid", 64'(dmem_req_valid), 64'd0);
        chk("late_rsp_stall", 64'(stall_out), 64'd0);
        @(posedge clk);
        #1;
      end
      dmem_rsp_valid = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
